// File: rtl/systolic_pkg.sv
// systolic_pkg: loader FSM state encoding and a clog2 helper, shared with result_unloader
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_A    = 3'd1,
        LOAD_B    = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    // Number of bits needed to index v items (0 for v <= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// matrix_loader: streams matrix A then B into BRAMs, starts the multiplier and waits for done
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   load_req                          begin a frame (sampled in IDLE only)
//   s_data, s_valid, s_ready          element stream, A row-major then B row-major
//   we_a/addr_a/din_a, we_b/...       registered BRAM write ports
//   mm_start, mm_done                 multiplier handshake
//   busy, frame_done, err_timeout     status
module matrix_loader
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int P          = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  we_a,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] din_b,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_timeout
);

    localparam int NA = M * N;
    localparam int NB = N * P;
    localparam int CW = clog2(NA > NB ? NA : NB) + 1;
    // One spare bit so the post-expiry increment cannot wrap.
    localparam int TW = clog2(TIMEOUT) + 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          acc;
    logic          last;
    logic          expire;

    assign s_ready = (state == LOAD_A) || (state == LOAD_B);
    assign busy    = (state != IDLE);
    assign acc     = s_valid && s_ready;
    assign last    = cnt == ((state == LOAD_A) ? CW'(NA - 1) : CW'(NB - 1));
    assign expire  = (state == WAIT_DONE) && !mm_done && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = load_req ? LOAD_A : IDLE;
            LOAD_A:    state_nx = (acc && last) ? LOAD_B : LOAD_A;
            LOAD_B:    state_nx = (acc && last) ? START : LOAD_B;
            START:     state_nx = WAIT_DONE;
            WAIT_DONE: state_nx = (mm_done || expire) ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            we_a        <= 1'b0;
            we_b        <= 1'b0;
            addr_a      <= '0;
            addr_b      <= '0;
            din_a       <= '0;
            din_b       <= '0;
            mm_start    <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state      <= state_nx;
            // Any state change restarts the element count for the next matrix.
            cnt        <= (state != state_nx) ? '0 : acc ? cnt + 1'b1 : cnt;
            tcnt       <= (state == WAIT_DONE) ? tcnt + 1'b1 : '0;
            we_a       <= acc && (state == LOAD_A);
            we_b       <= acc && (state == LOAD_B);
            // Registered from START so the last B write lands one cycle before the pulse.
            mm_start   <= (state == START);
            frame_done <= (state == WAIT_DONE) && mm_done;
            if (acc && state == LOAD_A) begin
                addr_a <= ADDR_WIDTH'(cnt);
                din_a  <= s_data;
            end
            if (acc && state == LOAD_B) begin
                addr_b <= ADDR_WIDTH'(cnt);
                din_b  <= s_data;
            end
            if (state == IDLE && load_req)
                err_timeout <= 1'b0;
            else if (expire)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: scoreboard bench for matrix_loader (2x2x2 with short timeout, plus default 8x8)
module tb_matrix_loader;

    localparam int DW = 8;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          load_req = 1'b0, s_valid = 1'b0, mm_done = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, we_a, we_b, mm_start, busy, frame_done, err_timeout;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic          b_load_req = 1'b0, b_s_valid = 1'b0, b_mm_done = 1'b0;
    logic [DW-1:0] b_s_data = '0;
    logic          b_s_ready, b_we_a, b_we_b, b_mm_start, b_busy, b_frame_done, b_err_timeout;
    logic [AW-1:0] b_addr_a, b_addr_b;
    logic [DW-1:0] b_din_a, b_din_b;

    matrix_loader #(.DATA_WIDTH(DW), .M(2), .N(2), .P(2), .ADDR_WIDTH(AW), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .load_req(load_req), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .we_a(we_a), .we_b(we_b), .addr_a(addr_a), .addr_b(addr_b),
        .din_a(din_a), .din_b(din_b), .mm_start(mm_start), .mm_done(mm_done), .busy(busy),
        .frame_done(frame_done), .err_timeout(err_timeout)
    );

    matrix_loader u_big (
        .clk(clk), .rst(rst), .load_req(b_load_req), .s_data(b_s_data), .s_valid(b_s_valid),
        .s_ready(b_s_ready), .we_a(b_we_a), .we_b(b_we_b), .addr_a(b_addr_a), .addr_b(b_addr_b),
        .din_a(b_din_a), .din_b(b_din_b), .mm_start(b_mm_start), .mm_done(b_mm_done), .busy(b_busy),
        .frame_done(b_frame_done), .err_timeout(b_err_timeout)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected BRAM writes as {addr, data}.
    logic [AW+DW-1:0] exp_a[$], exp_b[$], bexp_a[$], bexp_b[$];

    int wa_n = 0, wb_n = 0, last_wb = 0, start_cyc = 0, start_n = 0;
    int bwa_n = 0, bwb_n = 0, b_last_addr = 0, b_start_n = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (we_a) begin
                wa_n++;
                check("a_write_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) check("a_write", {addr_a, din_a}, exp_a.pop_front());
            end
            if (we_b) begin
                wb_n++;
                last_wb = cyc;
                check("b_write_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) check("b_write", {addr_b, din_b}, exp_b.pop_front());
            end
            if (mm_start) begin
                start_n++;
                start_cyc = cyc;
            end
            if (b_we_a) begin
                bwa_n++;
                b_last_addr = int'(b_addr_a);
                check("big_a_write_expected", bexp_a.size() != 0, 1);
                if (bexp_a.size() != 0) check("big_a_write", {b_addr_a, b_din_a}, bexp_a.pop_front());
            end
            if (b_we_b) begin
                bwb_n++;
                check("big_b_write_expected", bexp_b.size() != 0, 1);
                if (bexp_b.size() != 0) check("big_b_write", {b_addr_b, b_din_b}, bexp_b.pop_front());
            end
            if (b_mm_start) b_start_n++;
        end
    end

    task automatic start_frame();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    // Offers n elements base, base+1, ...; first four go to A, the rest to B.
    task automatic feed(input int base, input bit gappy, input int n);
        int i = 0;
        int k = 0;
        bit ph = 1'b0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        while (i < n && k < 100) begin
            @(negedge clk);
            ph = gappy ? ~ph : 1'b1;
            d = DW'(base + i);
            s_valid = ph;
            s_data = d;
            if (ph && s_ready) begin
                a = AW'(i < 4 ? i : i - 4);
                if (i < 4) exp_a.push_back({a, d});
                else exp_b.push_back({a, d});
                i++;
            end
            k++;
        end
        check("feed_all_accepted", i, n);
        @(negedge clk) s_valid = 1'b0;
    endtask

    task automatic wait_start();
        int k = 0;
        while (!mm_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mm_start_seen", mm_start, 1);
        #1;
    endtask

    task automatic finish_frame(input int wa0, input int wb0, input int st0);
        check("start_after_last_wb", start_cyc - last_wb, 1);
        @(negedge clk) mm_done = 1'b1;
        @(negedge clk) mm_done = 1'b0;
        check("frame_done", frame_done, 1);
        check("busy_after_done", busy, 0);
        check("err_after_done", err_timeout, 0);
        check("a_write_count", wa_n - wa0, 4);
        check("b_write_count", wb_n - wb0, 4);
        check("start_pulses", start_n - st0, 1);
        check("queues_drained", exp_a.size() + exp_b.size(), 0);
        @(negedge clk);
        check("frame_done_pulse", frame_done, 0);
    endtask

    initial begin
        int n;
        int i;
        int k;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_idle", {busy, s_ready, we_a, we_b, mm_start, frame_done, err_timeout}, 0);

        // Reset in the middle of LOAD_B.
        start_frame();
        feed(100, 1'b0, 6);
        check("mid_load_b_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs",
              {busy, s_ready, we_a, we_b, addr_a, addr_b, din_a, din_b, mm_start, frame_done, err_timeout}, 0);
        check("reset_queues", exp_a.size() + exp_b.size(), 0);
        @(negedge clk) rst = 1'b1;

        // Full frame, back-to-back stream.
        n = wa_n; i = wb_n; k = start_n;
        start_frame();
        check("load_a_busy", busy, 1);
        check("load_a_ready", s_ready, 1);
        feed(1, 1'b0, 8);
        wait_start();
        finish_frame(n, i, k);

        // Gappy stream.
        n = wa_n; i = wb_n; k = start_n;
        start_frame();
        feed(10, 1'b1, 8);
        wait_start();
        finish_frame(n, i, k);

        // Timeout: mm_done never arrives.
        start_frame();
        feed(20, 1'b0, 8);
        wait_start();
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", n, 16);
        check("timeout_err", err_timeout, 1);
        check("timeout_no_frame_done", frame_done, 0);
        @(negedge clk) mm_done = 1'b1;
        @(negedge clk) mm_done = 1'b0;
        check("idle_done_ignored", frame_done, 0);
        check("err_sticky", err_timeout, 1);
        start_frame();
        check("err_cleared_on_load", err_timeout, 0);

        // mm_done arrives in the expiry cycle: done wins.
        feed(30, 1'b0, 8);
        wait_start();
        repeat (15) @(negedge clk);
        check("busy_at_expiry", busy, 1);
        mm_done = 1'b1;
        @(negedge clk) mm_done = 1'b0;
        check("tie_frame_done", frame_done, 1);
        check("tie_err", err_timeout, 0);
        check("tie_busy", busy, 0);

        // Default 8x8 with load_req held high.
        @(negedge clk) b_load_req = 1'b1;
        i = 0;
        k = 0;
        while (i < 128 && k < 400) begin
            @(negedge clk);
            d = DW'(i * 3 + 1);
            b_s_valid = 1'b1;
            b_s_data = d;
            if (b_s_ready) begin
                a = AW'(i % 64);
                if (i < 64) bexp_a.push_back({a, d});
                else bexp_b.push_back({a, d});
                i++;
            end
            k++;
        end
        check("big_all_accepted", i, 128);
        @(negedge clk) b_s_valid = 1'b0;
        k = 0;
        while (!b_mm_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("big_mm_start_seen", b_mm_start, 1);
        @(negedge clk) b_load_req = 1'b0;
        @(negedge clk) b_load_req = 1'b1;
        repeat (4) @(negedge clk);
        check("big_busy_in_wait", b_busy, 1);
        check("big_start_pulses", b_start_n, 1);
        b_mm_done = 1'b1;
        b_load_req = 1'b0;
        @(negedge clk) b_mm_done = 1'b0;
        check("big_frame_done", b_frame_done, 1);
        check("big_a_count", bwa_n, 64);
        check("big_b_count", bwb_n, 64);
        check("big_last_addr", b_last_addr, 63);
        check("big_queues_drained", bexp_a.size() + bexp_b.size(), 0);
        @(negedge clk);
        check("big_idle_after", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
